sort_bank_cnt_ctrl: RTL
=======================

Name: sort_bank_cnt_ctrl

Overview:
- Count-accumulate controller that sits directly upstream of the sort bank memory wrapper and drives its wr/rd ports.
- Runs three phases in order:
  - Clears every bank entry to zero.
  - Accumulates a key stream by read-modify-write increment of the per-key count.
  - Drains all counts in address order over a valid/ready stream to the next sort stage.
- The bank port is treated as single-address: rd and wr are never issued in the same cycle.

Parameters:
- ADDR_WIDTH, 4: key/address width. DEPTH = 2^ADDR_WIDTH entries.
- DATA_WIDTH, 10: counter width. Counts saturate at 2^DATA_WIDTH-1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset.
- clr_start  in  1  start clear phase; honoured only in IDLE.
- acc_end  in  1  end accumulate phase; honoured only in ACCUM.
- drn_start  in  1  start drain phase; honoured only in IDLE.
- key_vld  in  1  key valid.
- key_rdy  out  1  key accepted when key_vld&key_rdy.
- key  in  ADDR_WIDTH  key to count.
- out_vld  out  1  drained entry valid.
- out_rdy  in  1  downstream ready.
- out_addr  out  ADDR_WIDTH  drained key.
- out_cnt  out  DATA_WIDTH  drained count.
- clr_done / acc_done / drn_done  out  1 each  one-cycle phase-completion pulses.
- sat_err  out  1  sticky: an increment hit saturation. Cleared by clr_start.
- busy  out  1  state != IDLE.
- mem_wr_vld, mem_wr_addr, mem_data_in  out  1/ADDR_WIDTH/DATA_WIDTH  bank write port.
- mem_rd_vld, mem_rd_addr  out  1/ADDR_WIDTH  bank read port.
- mem_data_out  in  DATA_WIDTH  bank read data, valid exactly 1 cycle after mem_rd_vld.

Behaviour:
- Reset (rst==0 at posedge):
  - State goes to IDLE.
  - All vld/done/busy/key_rdy/sat_err outputs 0; out_addr/out_cnt 0; clear pointer, drain pointer and in-flight flags 0.
  - An in-flight write is dropped. Bank contents are not restored.
- States: IDLE, CLEAR, ACCUM, DRAIN.
- IDLE:
  - If clr_start and drn_start are both high, clr_start wins.
  - clr_start -> CLEAR: pointer=0, sat_err=0.
  - drn_start -> DRAIN: pointer=0.
- CLEAR:
  - Each cycle: mem_wr_vld=1, mem_wr_addr=ptr, mem_data_in=0, then ptr++.
  - After the write to DEPTH-1: next cycle clr_done=1 and state=ACCUM.
  - Total: DEPTH write cycles, with clr_done in cycle DEPTH+1 after entry.
  - key_rdy=0 throughout.
- ACCUM:
  - key_rdy = (state==ACCUM) & !wb_pend & !end_pend, driven from registers only.
  - Accept in cycle n: mem_rd_vld=1, mem_rd_addr=key; wb_pend=1; wb_addr=key.
  - Cycle n+1:
    - mem_wr_vld=1, mem_wr_addr=wb_addr.
    - mem_data_in = (mem_data_out==all-ones) ? all-ones : mem_data_out+1.
    - If the value was saturated, sat_err=1.
    - key_rdy=0 this cycle.
  - Throughput: 1 key per 2 cycles. No forwarding is needed because a write always completes before the next read.
  - Repeated identical keys must count correctly.
  - acc_end sets end_pend. When !wb_pend, or at completion of the pending write: acc_done pulses the following cycle and state=IDLE.
  - A key accepted in the same cycle as acc_end is counted.
- DRAIN:
  - Issue mem_rd_vld for ptr when all of the following hold: !rd_inflight, ptr<=DEPTH-1 not exhausted, and (!out_vld | out_rdy).
  - On issue, ptr++.
  - Cycle after issue: out_vld=1, out_addr=issued addr, out_cnt=mem_data_out.
  - out_vld/out_addr/out_cnt hold stable while out_vld & !out_rdy.
  - out_vld drops the cycle after a handshake unless new data is captured in that same cycle.
  - Handshake of entry DEPTH-1: next cycle drn_done=1, out_vld=0, state=IDLE.
  - Drain never writes the bank.
- Never assert mem_rd_vld and mem_wr_vld in the same cycle. The bench asserts this.
- Inputs clr_start/drn_start/acc_end outside their honoured state are ignored.

Decomposition:
- Shared package sort_pkg:
  - State encoding constants ST_IDLE=2'd0, ST_CLEAR=2'd1, ST_ACCUM=2'd2, ST_DRAIN=2'd3.
  - A DEPTH helper.
- One natural sub-module: sort_cnt_sat_inc, a combinational saturating +1 with a sat flag.
- Registers use the team's CBB_REG-style flops with a synchronous active-low reset.

Test Plan (ADDR_WIDTH=4, DATA_WIDTH=4 unless noted):
- Reset mid-CLEAR at ptr=7:
  - busy=0 next cycle, no further mem_wr_vld.
  - A fresh clr_start produces 16 zero writes, addr 0..15, and clr_done in cycle 17.
- Accumulate keys 3,3,3,5 back-to-back:
  - key_rdy toggles 1,0,1,0, …
  - Drain yields cnt[3]=3, cnt[5]=1, all others 0, and acc_done follows acc_end.
- 17 accepts of key 9:
  - cnt[9]=15.
  - sat_err=1 after the 16th accept, stays 1 until the next clr_start.
- Drain with out_rdy low for 5 cycles on entry 2:
  - out_addr=2 and out_cnt held stable.
  - No mem_rd_vld issued while stalled.
  - All 16 entries emitted in order, drn_done after entry 15.
- clr_start and drn_start high together in IDLE: CLEAR entered, drain ignored.
- acc_end in the same cycle as an accepted key 4:
  - The key is counted.
  - acc_done pulses the cycle after its write.
  - rd/wr mutual-exclusion assertion holds throughout.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared definitions for the sort bank count controller: FSM state codes
// and the bank depth helper.
package sort_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_ACCUM = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    // Number of bank entries addressed by an aw-bit key.
    function automatic int unsigned depth_f(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

endpackage

// File: rtl/sort_cnt_sat_inc.sv
// Combinational saturating +1 for a bank count; sat flags an already
// saturated input.
module sort_cnt_sat_inc #(
    parameter int DATA_WIDTH = 10
) (
    input  logic [DATA_WIDTH-1:0] cnt,
    output logic [DATA_WIDTH-1:0] cnt_inc,
    output logic                  sat
);

    // All-ones stays all-ones; anything else increments.
    always_comb begin
        sat = &cnt;
        if (sat) begin
            cnt_inc = cnt;
        end else begin
            cnt_inc = cnt + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/sort_bank_cnt_ctrl.sv
// Count-accumulate controller in front of the sort bank: clears the bank,
// counts keys by read-modify-write, then drains counts over valid/ready.
module sort_bank_cnt_ctrl
    import sort_pkg::*;
#(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_start,
    input  logic                  acc_end,
    input  logic                  drn_start,
    input  logic                  key_vld,
    output logic                  key_rdy,
    input  logic [ADDR_WIDTH-1:0] key,
    output logic                  out_vld,
    input  logic                  out_rdy,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_cnt,
    output logic                  clr_done,
    output logic                  acc_done,
    output logic                  drn_done,
    output logic                  sat_err,
    output logic                  busy,
    output logic                  mem_wr_vld,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_rd_vld,
    output logic [ADDR_WIDTH-1:0] mem_rd_addr,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    localparam int unsigned DEPTH = depth_f(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   PTR_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [1:0]            st_r;
    logic [1:0]            st_nxt_s;
    // Extra MSB marks the drain pointer as exhausted.
    logic [ADDR_WIDTH:0]   ptr_r;
    logic                  wb_pend_r;
    logic [ADDR_WIDTH-1:0] wb_addr_r;
    logic                  end_pend_r;
    logic                  rd_inflight_r;
    logic [ADDR_WIDTH-1:0] rd_addr_r;
    logic                  out_vld_r;
    logic [ADDR_WIDTH-1:0] out_addr_r;
    logic [DATA_WIDTH-1:0] out_cnt_r;
    logic                  clr_done_r;
    logic                  acc_done_r;
    logic                  drn_done_r;
    logic                  sat_err_r;
    logic                  busy_r;

    logic                  key_rdy_s;
    logic                  accept_s;
    logic                  issue_s;
    logic                  clr_last_s;
    logic                  drn_last_s;
    logic [DATA_WIDTH-1:0] inc_cnt_s;
    logic                  inc_sat_s;
    logic                  mem_wr_vld_s;
    logic [ADDR_WIDTH-1:0] mem_wr_addr_s;
    logic [DATA_WIDTH-1:0] mem_data_in_s;
    logic                  mem_rd_vld_s;
    logic [ADDR_WIDTH-1:0] mem_rd_addr_s;

    sort_cnt_sat_inc #(.DATA_WIDTH(DATA_WIDTH)) u_sat_inc (
        .cnt     (mem_data_out),
        .cnt_inc (inc_cnt_s),
        .sat     (inc_sat_s)
    );

    assign key_rdy    = key_rdy_s;
    assign key_rdy_s  = (st_r == ST_ACCUM) & ~wb_pend_r & ~end_pend_r;
    assign accept_s   = key_vld & key_rdy_s;
    assign issue_s    = (st_r == ST_DRAIN) & ~rd_inflight_r & ~ptr_r[ADDR_WIDTH] &
                        (~out_vld_r | out_rdy);
    assign clr_last_s = (st_r == ST_CLEAR) & (ptr_r[ADDR_WIDTH-1:0] == LAST_ADDR);
    assign drn_last_s = (st_r == ST_DRAIN) & out_vld_r & out_rdy & (out_addr_r == LAST_ADDR);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            st_r <= ST_IDLE;
        end else begin
            st_r <= st_nxt_s;
        end
    end

    // Next-state decode; clr_start beats drn_start in IDLE.
    always_comb begin
        st_nxt_s = st_r;
        case (st_r)
            ST_IDLE: begin
                if (clr_start) begin
                    st_nxt_s = ST_CLEAR;
                end else if (drn_start) begin
                    st_nxt_s = ST_DRAIN;
                end else begin
                    st_nxt_s = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_last_s) begin
                    st_nxt_s = ST_ACCUM;
                end else begin
                    st_nxt_s = ST_CLEAR;
                end
            end
            ST_ACCUM: begin
                if (end_pend_r) begin
                    st_nxt_s = ST_IDLE;
                end else begin
                    st_nxt_s = ST_ACCUM;
                end
            end
            ST_DRAIN: begin
                if (drn_last_s) begin
                    st_nxt_s = ST_IDLE;
                end else begin
                    st_nxt_s = ST_DRAIN;
                end
            end
            default: st_nxt_s = ST_IDLE;
        endcase
    end

    // Bank port decode; the write-back always owns the cycle after an accept.
    always_comb begin
        mem_wr_vld_s  = 1'b0;
        mem_wr_addr_s = {ADDR_WIDTH{1'b0}};
        mem_data_in_s = {DATA_WIDTH{1'b0}};
        mem_rd_vld_s  = 1'b0;
        mem_rd_addr_s = {ADDR_WIDTH{1'b0}};
        case (st_r)
            ST_CLEAR: begin
                mem_wr_vld_s  = 1'b1;
                mem_wr_addr_s = ptr_r[ADDR_WIDTH-1:0];
            end
            ST_ACCUM: begin
                if (wb_pend_r) begin
                    mem_wr_vld_s  = 1'b1;
                    mem_wr_addr_s = wb_addr_r;
                    mem_data_in_s = inc_cnt_s;
                end else if (accept_s) begin
                    mem_rd_vld_s  = 1'b1;
                    mem_rd_addr_s = key;
                end else begin
                    mem_rd_vld_s  = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (issue_s) begin
                    mem_rd_vld_s  = 1'b1;
                    mem_rd_addr_s = ptr_r[ADDR_WIDTH-1:0];
                end else begin
                    mem_rd_vld_s  = 1'b0;
                end
            end
            default: mem_wr_vld_s = 1'b0;
        endcase
    end

    // A reset cycle drops any bank access the current state would issue.
    assign mem_wr_vld  = mem_wr_vld_s & rst;
    assign mem_wr_addr = mem_wr_addr_s;
    assign mem_data_in = mem_data_in_s;
    assign mem_rd_vld  = mem_rd_vld_s & rst;
    assign mem_rd_addr = mem_rd_addr_s;

    // Pointer, pending flags, output stage and status flops.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_r         <= {(ADDR_WIDTH+1){1'b0}};
            wb_pend_r     <= 1'b0;
            wb_addr_r     <= {ADDR_WIDTH{1'b0}};
            end_pend_r    <= 1'b0;
            rd_inflight_r <= 1'b0;
            rd_addr_r     <= {ADDR_WIDTH{1'b0}};
            out_vld_r     <= 1'b0;
            out_addr_r    <= {ADDR_WIDTH{1'b0}};
            out_cnt_r     <= {DATA_WIDTH{1'b0}};
            clr_done_r    <= 1'b0;
            acc_done_r    <= 1'b0;
            drn_done_r    <= 1'b0;
            sat_err_r     <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            if ((st_r == ST_IDLE) && (clr_start || drn_start)) begin
                ptr_r <= {(ADDR_WIDTH+1){1'b0}};
            end else if ((st_r == ST_CLEAR) || issue_s) begin
                ptr_r <= ptr_r + PTR_ONE;
            end

            wb_pend_r <= accept_s;
            if (accept_s) begin
                wb_addr_r <= key;
            end

            if ((st_r == ST_ACCUM) && end_pend_r) begin
                end_pend_r <= 1'b0;
            end else if ((st_r == ST_ACCUM) && acc_end) begin
                end_pend_r <= 1'b1;
            end

            if ((st_r == ST_IDLE) && clr_start) begin
                sat_err_r <= 1'b0;
            end else if ((st_r == ST_ACCUM) && wb_pend_r && inc_sat_s) begin
                sat_err_r <= 1'b1;
            end

            rd_inflight_r <= issue_s;
            if (issue_s) begin
                rd_addr_r <= ptr_r[ADDR_WIDTH-1:0];
            end

            // Capture and handshake cannot coincide: issue needs the stage free.
            if (rd_inflight_r) begin
                out_vld_r  <= 1'b1;
                out_addr_r <= rd_addr_r;
                out_cnt_r  <= mem_data_out;
            end else if (out_vld_r && out_rdy) begin
                out_vld_r  <= 1'b0;
            end

            clr_done_r <= clr_last_s;
            acc_done_r <= (st_r == ST_ACCUM) && end_pend_r;
            drn_done_r <= drn_last_s;
            busy_r     <= (st_nxt_s != ST_IDLE);
        end
    end

    assign out_vld  = out_vld_r;
    assign out_addr = out_addr_r;
    assign out_cnt  = out_cnt_r;
    assign clr_done = clr_done_r;
    assign acc_done = acc_done_r;
    assign drn_done = drn_done_r;
    assign sat_err  = sat_err_r;
    assign busy     = busy_r;

endmodule
